usart_rx_fifo: RTL and testbench

Receive-side byte buffer that sits directly downstream of the USART receiver, on the comm_clock side of its valid/ready output.
- Accepts received bytes and a per-byte error flag.
- Stores them in a power-of-two circular FIFO.
- Presents them first-word-fall-through to the CPU/bus side, with fill status, sticky overrun and a watermark interrupt.
- Absorbs bursts so the receiver's RTS flow control only asserts when software falls behind by a full buffer.

---
 rtl/usart_pkg.sv | 15 +
 rtl/usart_fifo_mem.sv | 26 ++
 rtl/usart_rx_fifo.sv | 112 +++++++++++
 tb/tb_usart_rx_fifo.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/usart_pkg.sv
// Shared USART definitions: payload width, receive-entry layout and the
// default receive FIFO geometry used when integrating usart_rx/usart_tx.
package usart_pkg;

    localparam int unsigned USART_DATA_WIDTH    = 8;
    localparam int unsigned USART_RX_DEPTH_LOG2 = 4;
    localparam int unsigned USART_RX_WATERMARK  = 8;

    // One received byte plus the framing error seen while receiving it.
    typedef struct packed {
        logic                        error;
        logic [USART_DATA_WIDTH-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/usart_fifo_mem.sv
// Simple dual-port register array: one clocked write port, one
// asynchronous read port. Contents are intentionally not reset.
module usart_fifo_mem #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned WIDTH      = 9
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

    // Store one entry per enabled write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/usart_rx_fifo.sv
// Receive-side byte buffer between the USART receiver and the bus side.
// First-word-fall-through output, registered fill status, sticky overrun
// and a watermark interrupt. DROP_ON_FULL selects backpressure (0) or
// always-ready with drop-and-flag (1) behaviour when the buffer is full.
module usart_rx_fifo
    import usart_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2   = USART_RX_DEPTH_LOG2,
    parameter int unsigned DATA_WIDTH   = USART_DATA_WIDTH,
    parameter int unsigned WATERMARK    = USART_RX_WATERMARK,
    parameter bit          DROP_ON_FULL = 1'b0
) (
    input  logic                  comm_clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_error,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_error,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  flush,
    input  logic                  overrun_clear,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  overrun,
    output logic                  irq
);

    localparam int unsigned PW    = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 2**DEPTH_LOG2;

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr_n;
    logic [PW-1:0]         rd_ptr_n;
    logic [PW-1:0]         count_n;
    logic                  overrun_n;
    logic                  push;
    logic                  pop;
    logic                  drop;
    logic [DATA_WIDTH:0]   rd_entry;

    // Ready depends only on registered state and reset, never on out_ready.
    assign in_ready = reset && (DROP_ON_FULL || !full);

    // Full is judged on the pre-edge state, so a full FIFO in drop mode
    // loses the byte even if a pop happens on the same edge.
    assign push = in_valid && in_ready && !full && !flush;
    assign drop = in_valid && in_ready &&  full && !flush;
    assign pop  = !empty && out_ready && !flush;

    // Next pointer, fill level and overrun state.
    always_comb begin
        wr_ptr_n  = wr_ptr;
        rd_ptr_n  = rd_ptr;
        overrun_n = overrun;
        if (flush) begin
            wr_ptr_n = '0;
            rd_ptr_n = '0;
        end else begin
            if (push) wr_ptr_n = wr_ptr + PW'(1);
            if (pop)  rd_ptr_n = rd_ptr + PW'(1);
        end
        if (drop) begin
            overrun_n = 1'b1;
        end else if (overrun_clear) begin
            overrun_n = 1'b0;
        end
        count_n = wr_ptr_n - rd_ptr_n;
    end

    // Pointers and all status flags update together on the same edge.
    always_ff @(posedge comm_clock or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            empty   <= 1'b1;
            full    <= 1'b0;
            overrun <= 1'b0;
            irq     <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr_n;
            rd_ptr  <= rd_ptr_n;
            count   <= count_n;
            empty   <= (wr_ptr_n == rd_ptr_n);
            full    <= (count_n == PW'(DEPTH));
            overrun <= overrun_n;
            irq     <= (count_n >= PW'(WATERMARK)) || overrun_n;
        end
    end

    usart_fifo_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (DATA_WIDTH + 1)
    ) u_mem (
        .clk     (comm_clock),
        .wr_en   (push),
        .wr_addr (wr_ptr[DEPTH_LOG2-1:0]),
        .wr_data ({in_error, in_data}),
        .rd_addr (rd_ptr[DEPTH_LOG2-1:0]),
        .rd_data (rd_entry)
    );

    assign out_valid = !empty;
    assign out_data  = empty ? '0 : rd_entry[DATA_WIDTH-1:0];
    assign out_error = !empty && rd_entry[DATA_WIDTH];

endmodule

// File: tb/tb_usart_rx_fifo.sv
// Bench for usart_rx_fifo: one instance per DROP_ON_FULL mode, shared
// stimulus, a queue-based reference model per instance compared every
// cycle, plus literal expectations at key points of the directed sequence.
module tb_usart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_error = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       flush = 1'b0;
    logic       oclr = 1'b0;

    logic       in_ready_w  [2];
    logic [7:0] out_data_w  [2];
    logic       out_error_w [2];
    logic       out_valid_w [2];
    logic [4:0] count_w     [2];
    logic       empty_w     [2];
    logic       full_w      [2];
    logic       overrun_w   [2];
    logic       irq_w       [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    usart_rx_fifo #(.DEPTH_LOG2(4), .DATA_WIDTH(8), .WATERMARK(8), .DROP_ON_FULL(1'b0)) dut0 (
        .comm_clock(clk), .reset(rst_n), .in_data(in_data), .in_error(in_error),
        .in_valid(in_valid), .in_ready(in_ready_w[0]), .out_data(out_data_w[0]),
        .out_error(out_error_w[0]), .out_valid(out_valid_w[0]), .out_ready(out_ready),
        .flush(flush), .overrun_clear(oclr), .count(count_w[0]), .empty(empty_w[0]),
        .full(full_w[0]), .overrun(overrun_w[0]), .irq(irq_w[0])
    );

    usart_rx_fifo #(.DEPTH_LOG2(4), .DATA_WIDTH(8), .WATERMARK(8), .DROP_ON_FULL(1'b1)) dut1 (
        .comm_clock(clk), .reset(rst_n), .in_data(in_data), .in_error(in_error),
        .in_valid(in_valid), .in_ready(in_ready_w[1]), .out_data(out_data_w[1]),
        .out_error(out_error_w[1]), .out_valid(out_valid_w[1]), .out_ready(out_ready),
        .flush(flush), .overrun_clear(oclr), .count(count_w[1]), .empty(empty_w[1]),
        .full(full_w[1]), .overrun(overrun_w[1]), .irq(irq_w[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each FIFO is a queue of {error, data}.
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    bit         ovr [2];

    always @(posedge clk or negedge rst_n) begin
        logic [8:0] q[$];
        bit full_pre;
        bit dropped;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            ovr[0] = 1'b0;
            ovr[1] = 1'b0;
        end else begin
            for (int m = 0; m < 2; m++) begin
                if (m == 0) q = q0; else q = q1;
                full_pre = (q.size() == 16);
                dropped  = (m == 1) && in_valid && full_pre && !flush;
                if (flush) begin
                    q.delete();
                end else begin
                    if (q.size() > 0 && out_ready) void'(q.pop_front());
                    if (in_valid && !full_pre) q.push_back({in_error, in_data});
                end
                if (dropped) ovr[m] = 1'b1;
                else if (oclr) ovr[m] = 1'b0;
                if (m == 0) q0 = q; else q1 = q;
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        logic [8:0] q[$];
        int n;
        for (int m = 0; m < 2; m++) begin
            if (m == 0) q = q0; else q = q1;
            n = q.size();
            chk($sformatf("m%0d_count", m), 32'(count_w[m]), 32'(n));
            chk($sformatf("m%0d_empty", m), 32'(empty_w[m]), 32'(n == 0));
            chk($sformatf("m%0d_full", m), 32'(full_w[m]), 32'(n == 16));
            chk($sformatf("m%0d_out_valid", m), 32'(out_valid_w[m]), 32'(n != 0));
            chk($sformatf("m%0d_out_data", m), 32'(out_data_w[m]), (n != 0) ? 32'(q[0][7:0]) : 32'h0);
            chk($sformatf("m%0d_out_error", m), 32'(out_error_w[m]), (n != 0) ? 32'(q[0][8]) : 32'h0);
            chk($sformatf("m%0d_overrun", m), 32'(overrun_w[m]), 32'(ovr[m]));
            chk($sformatf("m%0d_irq", m), 32'(irq_w[m]), 32'((n >= 8) || ovr[m]));
            chk($sformatf("m%0d_in_ready", m), 32'(in_ready_w[m]), 32'(rst_n && (m == 1 || n < 16)));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_d [3];
        logic       exp_e [3];
        int         maxc;
        exp_d[0] = 8'h41; exp_d[1] = 8'h42; exp_d[2] = 8'h43;
        exp_e[0] = 1'b0;  exp_e[1] = 1'b1;  exp_e[2] = 1'b0;

        // Reset state
        repeat (2) step();
        @(negedge clk);
        chk("rst_count", 32'(count_w[0]), 32'h0);
        chk("rst_empty", 32'(empty_w[0]), 32'h1);
        chk("rst_in_ready_m1", 32'(in_ready_w[1]), 32'h0);
        step();
        rst_n = 1'b1;
        step();

        // Three pushes, then three pops in order
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = exp_d[i]; in_error = exp_e[i];
            step();
        end
        in_valid = 1'b0; in_error = 1'b0;
        @(negedge clk);
        chk("t1_count", 32'(count_w[0]), 32'h3);
        chk("t1_head", 32'(out_data_w[0]), 32'h41);
        chk("t1_head_err", 32'(out_error_w[0]), 32'h0);
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("t1_pop%0d_data", i), 32'(out_data_w[0]), 32'(exp_d[i]));
            chk($sformatf("t1_pop%0d_err", i), 32'(out_error_w[0]), 32'(exp_e[i]));
            step();
        end
        out_ready = 1'b0;
        @(negedge clk);
        chk("t1_empty", 32'(empty_w[0]), 32'h1);
        chk("t1_out_data0", 32'(out_data_w[0]), 32'h0);
        step();

        // Fill with 17 bytes: mode 0 holds 0x10 upstream, mode 1 drops it
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1; in_data = 8'(i);
            step();
        end
        @(negedge clk);
        chk("t2_full_m0", 32'(full_w[0]), 32'h1);
        chk("t2_in_ready_m0", 32'(in_ready_w[0]), 32'h0);
        chk("t2_overrun_m0", 32'(overrun_w[0]), 32'h0);
        chk("t2_overrun_m1", 32'(overrun_w[1]), 32'h1);
        chk("t2_irq_m1", 32'(irq_w[1]), 32'h1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t2_refill_count_m0", 32'(count_w[0]), 32'h10);
        chk("t2_refill_overrun_m0", 32'(overrun_w[0]), 32'h0);
        oclr = 1'b1;
        step();
        oclr = 1'b0;
        @(negedge clk);
        chk("t2_oclr_overrun_m1", 32'(overrun_w[1]), 32'h0);
        chk("t2_oclr_irq_m1", 32'(irq_w[1]), 32'h1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();

        // Streaming 40 bytes with push and pop every cycle
        maxc = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            in_data = 8'(8'h80 + i);
            in_error = 1'(i % 3 == 0);
            step();
            @(negedge clk);
            if (int'(count_w[0]) > maxc) maxc = int'(count_w[0]);
        end
        in_valid = 1'b0; in_error = 1'b0;
        step();
        out_ready = 1'b0;
        chk("t3_max_count_le1", 32'(maxc <= 1), 32'h1);
        @(negedge clk);
        chk("t3_drained", 32'(empty_w[0]), 32'h1);
        chk("t3_no_overrun_m1", 32'(overrun_w[1]), 32'h0);

        // Watermark
        step();
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_data = 8'(8'hA0 + i);
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("t4_irq_at7", 32'(irq_w[0]), 32'h0);
        in_valid = 1'b1; in_data = 8'hA7;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t4_irq_at8", 32'(irq_w[0]), 32'h1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        @(negedge clk);
        chk("t4_irq_after_pop", 32'(irq_w[0]), 32'h0);

        // Reset with 5 entries held, upstream byte held through reset
        out_ready = 1'b1;
        step();
        step();
        out_ready = 1'b0;
        @(negedge clk);
        chk("t5_count5", 32'(count_w[0]), 32'h5);
        step();
        in_valid = 1'b1; in_data = 8'h99;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_count_now", 32'(count_w[0]), 32'h0);
        chk("t5_rst_valid_now", 32'(out_valid_w[0]), 32'h0);
        chk("t5_rst_in_ready", 32'(in_ready_w[0]), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t5_after_rel_count", 32'(count_w[0]), 32'h1);
        chk("t5_after_rel_data", 32'(out_data_w[1]), 32'h99);

        // Flush beats a same-cycle push
        step();
        flush = 1'b1; in_valid = 1'b1; in_data = 8'h55;
        step();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("t6_flush_count", 32'(count_w[0]), 32'h0);
        chk("t6_flush_data", 32'(out_data_w[0]), 32'h0);
        step();
        @(negedge clk);
        chk("t6_flush_not_stored", 32'(count_w[1]), 32'h0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
